// File: rtl/noc_pkg.sv
// Shared NoC router definitions: direction encodings, input indices,
// flit width and the round-robin pointer wrap helper.
package noc_pkg;

    localparam int FLIT_W = 64;
    localparam int NUM_IN = 5;

    // One-hot output direction codes.
    localparam logic [4:0] DIR_L  = 5'b10000;
    localparam logic [4:0] DIR_R  = 5'b01000;
    localparam logic [4:0] DIR_U  = 5'b00100;
    localparam logic [4:0] DIR_D  = 5'b00010;
    localparam logic [4:0] DIR_PE = 5'b00001;

    // Input indices into the request vector.
    localparam logic [2:0] IDX_L  = 3'd4;
    localparam logic [2:0] IDX_R  = 3'd3;
    localparam logic [2:0] IDX_U  = 3'd2;
    localparam logic [2:0] IDX_D  = 3'd1;
    localparam logic [2:0] IDX_PE = 3'd0;

    // Next lower-priority index, descending with wrap 0 -> 4.
    function automatic logic [2:0] next_ptr(input logic [2:0] idx);
        return (idx == IDX_PE) ? IDX_L : idx - 3'd1;
    endfunction

endpackage

// File: rtl/output_arbiter_if.sv
// Output-port bundle: requests and candidate flits from the five inputs,
// the send/ready handshake toward the neighbour, and the clear pulses back.
// master = the arbiter, slave = the surrounding router/environment.
interface output_arbiter_if #(
    parameter int DATA_WIDTH = noc_pkg::FLIT_W
);
    logic [4:0]            req_in;
    logic [DATA_WIDTH-1:0] data_l;
    logic [DATA_WIDTH-1:0] data_r;
    logic [DATA_WIDTH-1:0] data_u;
    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] data_pe;
    logic                  ro;
    logic                  so;
    logic [DATA_WIDTH-1:0] datao;
    logic [4:0]            buf_clear;
    logic [4:0]            grant;
    logic [4:0]            port_dir;

    modport master (
        input  req_in, data_l, data_r, data_u, data_d, data_pe, ro,
        output so, datao, buf_clear, grant, port_dir
    );

    modport slave (
        output req_in, data_l, data_r, data_u, data_d, data_pe, ro,
        input  so, datao, buf_clear, grant, port_dir
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans req from ptr downward with
// wrap 0 -> 4; the first set bit wins. gnt is one-hot (0 if no request).
module rr_pick
    import noc_pkg::*;
(
    input  logic [4:0] req,
    input  logic [2:0] ptr,
    output logic [4:0] gnt,
    output logic [2:0] win
);

    logic [2:0] idx;
    logic       found;

    // Priority scan starting at the pointer.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        gnt   = '0;
        win   = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int k = 0; k < NUM_IN; k++) begin
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                win      = idx;
            end
            idx = next_ptr(idx);
        end
    end

endmodule

// File: rtl/output_arbiter.sv
// Per-output-port arbiter: round-robin grant among five inputs, one-entry
// output register with send/ready handshake, registered buf_clear pulse.
// Optional build macro ARB_STALL_CNT_EN adds a saturating stall counter.
module output_arbiter
    import noc_pkg::*;
#(
    parameter int         DATA_WIDTH = FLIT_W,
    parameter logic [4:0] DIRECTION  = DIR_PE
) (
    input  logic               clk,
    input  logic               rst,
    output_arbiter_if.master   bus
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [15:0]        stall_cnt
`endif
);

    logic                  so_q, so_d;
    logic [DATA_WIDTH-1:0] datao_q, datao_d;
    logic [4:0]            buf_clear_q, buf_clear_d;
    logic [2:0]            ptr_q, ptr_d;

    logic [4:0]            eff_req;
    logic [4:0]            pick_gnt;
    logic [2:0]            pick_win;
    logic                  load_ok;
    logic [4:0]            grant;
    logic [DATA_WIDTH-1:0] cand [NUM_IN];

    assign cand[IDX_L]  = bus.data_l;
    assign cand[IDX_R]  = bus.data_r;
    assign cand[IDX_U]  = bus.data_u;
    assign cand[IDX_D]  = bus.data_d;
    assign cand[IDX_PE] = bus.data_pe;

    // An input being cleared this cycle still shows its old request; mask it
    // so the same flit cannot win twice.
    assign eff_req = bus.req_in & ~buf_clear_q;
    assign load_ok = !so_q || bus.ro;

    rr_pick u_pick (
        .req (eff_req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .win (pick_win)
    );

    // Next-state: load winner, drain on transfer, otherwise hold.
    always_comb begin
        so_d        = so_q;
        datao_d     = datao_q;
        ptr_d       = ptr_q;
        grant       = load_ok ? pick_gnt : 5'b0;
        buf_clear_d = grant;
        if (grant != 5'b0) begin
            datao_d = cand[pick_win];
            so_d    = 1'b1;
            ptr_d   = next_ptr(pick_win);
        end else if (so_q && bus.ro) begin
            so_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst) begin
            so_q        <= 1'b0;
            datao_q     <= '0;
            buf_clear_q <= '0;
            ptr_q       <= IDX_L;
        end else begin
            so_q        <= so_d;
            datao_q     <= datao_d;
            buf_clear_q <= buf_clear_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.so        = so_q;
    assign bus.datao     = datao_q;
    assign bus.buf_clear = buf_clear_q;
    assign bus.grant     = grant;
    assign bus.port_dir  = DIRECTION;

`ifdef ARB_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Count cycles where a held flit is blocked downstream; saturate.
    always_comb begin
        stall_d = stall_q;
        if (so_q && !bus.ro && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_output_arbiter.sv
// Self-checking bench for output_arbiter. A priority-queue model predicts
// every output each cycle; directed literal checks pin key scenarios.
module tb_output_arbiter;
    import noc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    output_arbiter_if #(.DATA_WIDTH(64)) bus ();
`ifdef ARB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    output_arbiter #(.DATA_WIDTH(64), .DIRECTION(5'b00001)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    int          prio[$];      // highest priority first
    bit          m_so;
    logic [63:0] m_data;
    logic [4:0]  m_clear;
    logic [15:0] m_stall;

    function automatic int pick(input logic [4:0] r);
        foreach (prio[i]) if (r[prio[i]]) return prio[i];
        return -1;
    endfunction

    function automatic logic [63:0] cand(input int w);
        case (w)
            4:       return bus.data_l;
            3:       return bus.data_r;
            2:       return bus.data_u;
            1:       return bus.data_d;
            default: return bus.data_pe;
        endcase
    endfunction

    function automatic logic [4:0] exp_grant();
        int w;
        if (m_so && !bus.ro) return 5'b0;
        w = pick(bus.req_in & ~m_clear);
        if (w < 0) return 5'b0;
        return 5'(1 << w);
    endfunction

    always @(posedge clk) begin : model_upd
        logic [4:0] g;
        int         w;
        if (!rst) begin
            prio    = {4, 3, 2, 1, 0};
            m_so    = 1'b0;
            m_data  = '0;
            m_clear = '0;
            m_stall = '0;
        end else begin
            g = exp_grant();
            if (m_so && !bus.ro && m_stall != 16'hFFFF) m_stall++;
            if (g != 5'b0) begin
                w      = pick(bus.req_in & ~m_clear);
                m_data = cand(w);
                m_so   = 1'b1;
                while (prio[$] != w) prio.push_back(prio.pop_front());
            end else if (m_so && bus.ro) begin
                m_so = 1'b0;
            end
            m_clear = g;
        end
    end

    // Compare process: every cycle, mid-low-phase.
    always @(negedge clk) begin
        if (chk_en) begin
            #2;
            check("so", bus.so, m_so);
            check("datao", bus.datao, m_data);
            check("buf_clear", bus.buf_clear, m_clear);
            check("grant", bus.grant, exp_grant());
            check("port_dir", bus.port_dir, 5'b00001);
`ifdef ARB_STALL_CNT_EN
            check("stall_cnt", stall_cnt, m_stall);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    logic [4:0] exp_rr [5] = '{5'b10000, 5'b01000, 5'b00100, 5'b00010, 5'b00001};
    logic [15:0] st0;

    initial begin
        rst         = 1'b0;
        bus.req_in  = '0;
        bus.ro      = 1'b1;
        bus.data_l  = 64'h1111_0000_0000_0004;
        bus.data_r  = 64'h2222_0000_0000_0003;
        bus.data_u  = 64'h3333_0000_0000_0002;
        bus.data_d  = 64'h4444_0000_0000_0001;
        bus.data_pe = 64'h5555_0000_0000_0000;
        st0         = '0;

        // Reset state.
        @(negedge clk);
        chk_en = 1'b1;
        #3;
        check("rst_so", bus.so, 1'b0);
        check("rst_datao", bus.datao, 64'h0);
        check("rst_grant", bus.grant, 5'b0);
        check("rst_clear", bus.buf_clear, 5'b0);

        // Single U request.
        @(negedge clk);
        rst = 1'b1; bus.req_in = 5'b00100; bus.data_u = 64'hA5;
        #3 check("t1_grant", bus.grant, 5'b00100);
        @(negedge clk);
        #3;
        check("t1_so", bus.so, 1'b1);
        check("t1_datao", bus.datao, 64'hA5);
        check("t1_clear", bus.buf_clear, 5'b00100);
        check("t1_no_regrant", bus.grant, 5'b0);
        @(negedge clk);
        bus.req_in = '0;
        #3;
        check("t1_clear_gone", bus.buf_clear, 5'b0);
        check("t1_drained", bus.so, 1'b0);

        // All inputs requesting continuously: L,R,U,D,PE,L...
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; bus.req_in = 5'b11111;
        for (int c = 0; c < 10; c++) begin
            bus.data_l  = 64'h4000 + 64'(c);
            bus.data_r  = 64'h3000 + 64'(c);
            bus.data_u  = 64'h2000 + 64'(c);
            bus.data_d  = 64'h1000 + 64'(c);
            bus.data_pe = 64'h0F00 + 64'(c);
            #3 check("rr_order", bus.grant, exp_rr[c % 5]);
            if (c > 0) check("rr_full", bus.so, 1'b1);
            @(negedge clk);
        end

        // Stall: L flit held with ro=0 for 4 cycles while PE requests.
        bus.req_in = '0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; bus.req_in = 5'b10000; bus.ro = 1'b1; bus.data_l = 64'hC0DE;
        @(negedge clk);
        bus.req_in = 5'b00001; bus.ro = 1'b0; bus.data_pe = 64'hBEEF;
        #3;
`ifdef ARB_STALL_CNT_EN
        st0 = stall_cnt;
`endif
        for (int s = 0; s < 4; s++) begin
            if (s > 0) #3;
            check("stall_so", bus.so, 1'b1);
            check("stall_datao", bus.datao, 64'hC0DE);
            check("stall_grant", bus.grant, 5'b0);
            if (s > 0) check("stall_clear", bus.buf_clear, 5'b0);
            @(negedge clk);
        end
        bus.ro = 1'b1;
        #3;
        check("unstall_grant", bus.grant, 5'b00001);
`ifdef ARB_STALL_CNT_EN
        check("stall_cnt4", stall_cnt - st0, 16'd4);
`endif
        @(negedge clk);
        bus.req_in = '0;
        #3;
        check("pe_loaded", bus.datao, 64'hBEEF);
        check("pe_clear", bus.buf_clear, 5'b00001);

        // Reset while holding a stalled flit; pointer must return to L.
        @(negedge clk);
        bus.req_in = 5'b00100; bus.ro = 1'b1;
        @(negedge clk);
        bus.req_in = '0; bus.ro = 1'b0; rst = 1'b0;
        #3 check("pre_rst_so", bus.so, 1'b1);
        chk_en = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        rst = 1'b1; bus.req_in = 5'b10001; bus.ro = 1'b1;
        #3;
        check("post_rst_so", bus.so, 1'b0);
        check("post_rst_L_wins", bus.grant, 5'b10000);
        @(negedge clk);
        bus.req_in = 5'b00001;
        #3 check("post_rst_datao", bus.datao, bus.data_l);
        @(negedge clk);
        bus.req_in = '0;

        // Request still high during its buf_clear cycle.
        @(negedge clk);
        bus.req_in = 5'b01000;
        #3 check("r_grant", bus.grant, 5'b01000);
        @(negedge clk);
        #3;
        check("r_clear", bus.buf_clear, 5'b01000);
        check("r_no_second", bus.grant, 5'b0);
        @(negedge clk);
        bus.req_in = '0;
        #3;
        check("idle_so", bus.so, 1'b0);
        check("idle_grant", bus.grant, 5'b0);
        repeat (3) @(negedge clk);

`ifdef ARB_STALL_CNT_EN
        // Saturation of the stall counter.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1; bus.req_in = 5'b00010; bus.ro = 1'b1;
        @(negedge clk);
        bus.req_in = '0; bus.ro = 1'b0;
        repeat (70000) @(negedge clk);
        #3 check("stall_sat", stall_cnt, 16'hFFFF);
        bus.ro = 1'b1;
        @(negedge clk);
`endif

        chk_en = 1'b0;
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/output_arbiter.md
Name: output_arbiter

Overview:
- One per router output port (L, R, U, D, PE). Shares that port among the five input interfaces that request it.
- Round-robin arbitration over the per-input request vectors. Latches the winner's flit into a one-entry output register and pulses the matching buffer-clear back to that input.
- Drives the send/ready handshake toward the neighbouring router or PE.

Parameters:
- DATA_WIDTH, 64, flit width.
- DIRECTION, 5'b00001, output direction served (L:10000, R:01000, U:00100, D:00010, PE:00001); informational, constant-reported on port_dir.
- NUM_IN, 5, number of requesting inputs; fixed at 5, index 4=L, 3=R, 2=U, 1=D, 0=PE.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-low reset (asserted when 0).
- req_in  input  5  bit i set = input i holds a flit for this output (OR-reduced reqX from input interface i).
- data_l, data_r, data_u, data_d, data_pe  input  DATA_WIDTH each  candidate flits from inputs 4..0.
- ro  input  1  downstream ready; transfer occurs on a cycle with so=1 and ro=1.
- so  output  1  output register holds a valid flit.
- datao  output  DATA_WIDTH  output register contents.
- buf_clear  output  5  one-hot, one-cycle pulse to the granted input; wired to that input's buf_clear_n.
- grant  output  5  one-hot winner of the current cycle's arbitration (0 when none).
- port_dir  output  5  equals DIRECTION.

Behaviour:
- Reset (rst=0 at a clock edge): so=0, datao=0, buf_clear=0, grant=0, rr pointer=4 (L highest priority). Reset mid-transfer discards the held flit; the input keeps its own buffer, so no flit is lost.
- load_ok = !so | ro (register empty, or being drained this cycle).
- Arbitration is combinational each cycle. Search req_in starting at pointer and descending with wrap 0→4. First set bit wins. grant = winner if load_ok and req_in≠0, else 0.
- On a clock edge with grant≠0:
  - datao ← winner's data.
  - so ← 1.
  - buf_clear ← grant (registered, so the pulse is high exactly the following cycle).
  - pointer ← winner−1 mod 5 (winner becomes lowest priority).
- On an edge with so=1, ro=1 and grant=0: so ← 0; datao holds its stale value.
- so=1 and ro=0: datao, so and pointer hold; grant=0; no clears.
- Throughput: one flit per cycle when ro stays high (back-to-back reload).
- Latency: req_in to so = 1 cycle; req_in to buf_clear = 1 cycle.
- The cleared input drops its request on the cycle after buf_clear. The arbiter ignores req_in[i] on any cycle where buf_clear[i]=1, so the same flit is never granted twice.
- Idle/empty: req_in=0 and register empty → so=0, grant=0, pointer unchanged.
- A request on the input whose bit equals DIRECTION (U-turn) is arbitrated normally; routing_algo never generates it.

Optional Feature:
- Macro ARB_STALL_CNT_EN.
- When defined: extra output stall_cnt [15:0]. Increments on every cycle with so=1 and ro=0, saturates at 16'hFFFF, cleared by reset only.
- When undefined: neither the port nor the counter exists; all other behaviour is identical.

Decomposition:
- Shared package noc_pkg:
  - direction one-hot constants DIR_L/R/U/D/PE.
  - index constants IDX_L=4 … IDX_PE=0.
  - FLIT_W=64.
  - function next_ptr(idx) for wrap-around.
- One sub-module, rr_pick: purely combinational. Inputs: 5-bit request and 3-bit pointer. Outputs: one-hot grant and 3-bit winner index. output_arbiter instantiates it and owns all state.

Test Plan:
- Reset then req_in=00100, data_u=64'hA5, ro=1 → next cycle so=1, datao=64'hA5, buf_clear=00100 for exactly one cycle.
- req_in=11111 held, every input re-requesting after its clear, ro=1 → grant order L,R,U,D,PE,L…; one flit per cycle; no input granted twice within 5 grants.
- Flit loaded, ro=0 for 4 cycles, req_in=00001 → so, datao stable; grant=0; buf_clear=0. ro=1 → PE flit loads on that edge.
- With ARB_STALL_CNT_EN: the same 4-cycle stall → stall_cnt=4. Force 70000 stall cycles → stall_cnt=16'hFFFF.
- rst=0 while so=1 and ro=0 → next cycle so=0, pointer=L. With req_in=10001 after reset → L wins first.
- req_in bit still high on the buf_clear cycle (e.g. 01000 with buf_clear=01000) → no second grant to R that cycle.
